// File: rtl/nibble_serial_addsub.sv
// Nibble-serial adder/subtractor: one 4-bit slice per cycle, LSB slice first,
// behind valid/ready handshakes on both the operand and the result side.
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   mode,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam int CNT_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_p0, b_p0;
  logic                mode_p0;
  logic                carry_p0;
  logic [CNT_W-1:0]    cnt_p0;
  logic                accept;
  logic                last_slice;
  logic [3:0]          a_sl, b_sl;
  logic [5:0]          slice_res;

  // Returns {carry into slice MSB, carry out, 4-bit sum}.
  function automatic logic [5:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [3:0] lo;
    logic [4:0] full;
    lo   = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, c};
    full = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    return {lo[3], full};
  endfunction

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state == RUN);
  assign accept     = in_valid && in_ready;
  assign last_slice = (cnt_p0 == CNT_W'(NIBBLES - 1));

  assign a_sl      = a_p0[{cnt_p0, 2'b00} +: 4];
  assign b_sl      = mode_p0 ? ~b_p0[{cnt_p0, 2'b00} +: 4] : b_p0[{cnt_p0, 2'b00} +: 4];
  assign slice_res = slice_add(a_sl, b_sl, carry_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p0: operand capture on accept; operands are frozen until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0    <= a;
      b_p0    <= b;
      mode_p0 <= mode;
    end
  end

  // Stage p1: serial slice datapath writing the result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      carry_p0 <= 1'b0;
      cnt_p0   <= '0;
    end else if (accept) begin
      carry_p0 <= mode ? 1'b1 : cin;
      cnt_p0   <= '0;
    end else if (state == RUN) begin
      s[{cnt_p0, 2'b00} +: 4] <= slice_res[3:0];
      carry_p0                <= slice_res[4];
      cnt_p0                  <= last_slice ? '0 : cnt_p0 + 1'b1;
      if (last_slice) begin
        cout <= slice_res[4];
        ovf  <= slice_res[5] ^ slice_res[4];
      end
    end
  end

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; the operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 SHALL have ports a and b, inputs, W bits each: the operands.
REQ-007 SHALL have port mode, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-008 SHALL have port cin, input, 1 bit: carry-in, used only when mode = 0.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port s, output, W bits: the result.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB (for subtract, 1 = no borrow).
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 SHALL have port busy, output, 1 bit: high while in state RUN.

Function
REQ-015 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE.
REQ-017 SHALL drive out_valid = 1 only in DONE.
REQ-018 SHALL treat the rising edge with in_valid & in_ready as accept; on accept, capture a, b and mode, set the carry register to (mode ? 1 : cin), clear the slice counter, and go IDLE -> RUN.
REQ-019 SHALL process one slice per RUN cycle, least-significant slice first, as a 4-bit ripple add of a_slice + (mode ? ~b_slice : b_slice) + carry.
REQ-020 SHALL write each slice sum into s[4k+3:4k] and register its carry-out for slice k+1.
REQ-021 SHALL stay in RUN for exactly NIBBLES cycles, then go RUN -> DONE; out_valid is high in the cycle NIBBLES+1 cycles after the accept edge.
REQ-022 SHALL set cout to the carry out of the last slice.
REQ-023 SHALL set ovf to the carry into bit W-1 XOR the carry out of bit W-1.
REQ-024 SHALL hold s, cout, ovf and out_valid stable in DONE until out_valid & out_ready.
REQ-025 SHALL go DONE -> IDLE on the edge where out_valid & out_ready; in_ready rises in the next cycle, and there is no accept on that same edge.
REQ-026 SHALL ignore in_valid while in RUN or DONE, and SHALL NOT change the captured operands after accept.
REQ-027 SHALL hold s, cout and ovf at their last values while in IDLE.
REQ-028 SHALL produce cout = 1 and s = 0 when mode = 1 and a == b.
REQ-029 SHALL wrap the result modulo 2^W; cout and ovf report the wrap, with no saturation.

Reset
REQ-030 SHALL, while rst_n = 0, force the state to IDLE, and in_ready = 1, out_valid = 0, busy = 0, s = 0, cout = 0, ovf = 0, the carry register to 0 and the slice counter to 0, asynchronously.
REQ-031 SHALL abort any operation in progress when rst_n is asserted during RUN or DONE; no result is ever presented for the aborted operation.
REQ-032 SHALL be able to accept a new operand set on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 SHALL be verified with mode=0, cin=0, a=0x1234, b=0x0FFF -> after 5 cycles, s=0x2233, cout=0, ovf=0.
REQ-034 SHALL be verified with mode=1, cin=1 (ignored), a=0x0003, b=0x0005 -> s=0xFFFE, cout=0 (borrow), ovf=0.
REQ-035 SHALL be verified with mode=0, a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; also mode=1, a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
REQ-036 SHALL be verified with mode=0, a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0.
REQ-037 SHALL be verified by holding out_ready=0 for 10 cycles in DONE while a and b toggle -> s, out_valid and in_ready=0 stay unchanged; pulsing out_ready=1 -> IDLE on the next edge.
REQ-038 SHALL be verified by asserting rst_n=0 in the 2nd RUN cycle -> outputs take reset values immediately, out_valid never rises, and a following 0x0001+0x0001 gives s=0x0002.
